// File: rtl/fakeram_1r1w_clr_if.sv
// fakeram_1r1w_clr_if
//   Request/response bundle for the 1R1W behavioural SRAM model.
//   slave  : the RAM side (drives ready_out, rd_v_out, rd_out).
//   master : the requester side (drives write and read requests).
//   Signals:
//     ready_out  - clear sequence done, requests are accepted
//     wr_v_in    - write request
//     wr_addr_in - write address
//     wd_in      - write data
//     w_mask_in  - per-bit write enable (1 = update bit)
//     rd_v_in    - read request
//     rd_addr_in - read address
//     rd_v_out   - rd_out carries the data of an accepted read
//     rd_out     - read data
interface fakeram_1r1w_clr_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 9
) ();
  logic                  ready_out;
  logic                  wr_v_in;
  logic [ADDR_WIDTH-1:0] wr_addr_in;
  logic [BITS-1:0]       wd_in;
  logic [BITS-1:0]       w_mask_in;
  logic                  rd_v_in;
  logic [ADDR_WIDTH-1:0] rd_addr_in;
  logic                  rd_v_out;
  logic [BITS-1:0]       rd_out;

  modport slave (
    output ready_out,
    input  wr_v_in,
    input  wr_addr_in,
    input  wd_in,
    input  w_mask_in,
    input  rd_v_in,
    input  rd_addr_in,
    output rd_v_out,
    output rd_out
  );

  modport master (
    input  ready_out,
    output wr_v_in,
    output wr_addr_in,
    output wd_in,
    output w_mask_in,
    output rd_v_in,
    output rd_addr_in,
    input  rd_v_out,
    input  rd_out
  );
endinterface

// File: rtl/fakeram_1r1w_clr.sv
// fakeram_1r1w_clr
//   Parametrised single-clock 1-read/1-write behavioural SRAM with
//   write-first forwarding, a valid-tagged read pipeline and a post-reset
//   clear sequencer that writes INIT_VAL to every word before ready_out rises.
//   Ports:
//     clk      - clock, all state on posedge
//     reset_in - asynchronous active-high reset
//     ram_if   - fakeram_1r1w_clr_if.slave request/response bundle
//   Optional feature:
//     FAKERAM_OUT_REG_EN - when defined, adds a second output register stage
//                          (read latency 2); otherwise read latency is 1.
module fakeram_1r1w_clr #(
  parameter int              BITS       = 64,
  parameter int              WORD_DEPTH = 512,
  parameter int              ADDR_WIDTH = 9,
  parameter logic [BITS-1:0] INIT_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset_in,
  fakeram_1r1w_clr_if.slave ram_if
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  function automatic logic [BITS-1:0] merge_masked(
    input logic [BITS-1:0] new_data,
    input logic [BITS-1:0] mask,
    input logic [BITS-1:0] old_data
  );
    return (new_data & mask) | (old_data & ~mask);
  endfunction

  logic [BITS-1:0]       mem [WORD_DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
  logic                  ready;

  logic                  wr_in_range, rd_in_range;
  logic                  wr_acc, rd_acc, collide;
  logic [BITS-1:0]       wr_old, wr_merged, rd_old, rd_data_p0;

  logic                  rd_v_p1_q;
  logic [BITS-1:0]       rd_data_p1_q;

  assign ready = (state_q == READY);

  // ---- stage p0: request decode, memory lookup, write-first forwarding ----
  assign wr_in_range = ({1'b0, ram_if.wr_addr_in} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, ram_if.rd_addr_in} < DEPTH_EXT);

  assign wr_acc = ready && ram_if.wr_v_in && wr_in_range;
  assign rd_acc = ready && ram_if.rd_v_in;

  assign wr_old    = wr_in_range ? mem[ram_if.wr_addr_in] : '0;
  assign wr_merged = merge_masked(ram_if.wd_in, ram_if.w_mask_in, wr_old);
  assign rd_old    = rd_in_range ? mem[ram_if.rd_addr_in] : '0;

  // A same-cycle write to the read address is forwarded so the read sees
  // post-write data; collide implies the read address is in range.
  assign collide    = wr_acc && rd_in_range && (ram_if.wr_addr_in == ram_if.rd_addr_in);
  assign rd_data_p0 = collide ? wr_merged : rd_old;

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == CLEAR) begin
      if (clear_cnt_q == LAST_ADDR) begin
        state_d = READY;
      end else begin
        clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Array has no reset; the clear sequencer owns it until READY.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      if (state_q == CLEAR) begin
        mem[clear_cnt_q] <= INIT_VAL;
      end else if (wr_acc) begin
        mem[ram_if.wr_addr_in] <= wr_merged;
      end
    end
  end

  // ---- stage p1: first output register ----
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= CLEAR;
      clear_cnt_q  <= '0;
      rd_v_p1_q    <= 1'b0;
      rd_data_p1_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      rd_v_p1_q   <= rd_acc;
      if (rd_acc) begin
        rd_data_p1_q <= rd_data_p0;
      end
    end
  end

`ifdef FAKERAM_OUT_REG_EN
  logic            rd_v_p2_q;
  logic [BITS-1:0] rd_data_p2_q;

  // ---- stage p2: optional second output register ----
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      rd_v_p2_q    <= 1'b0;
      rd_data_p2_q <= '0;
    end else begin
      rd_v_p2_q <= rd_v_p1_q;
      if (rd_v_p1_q) begin
        rd_data_p2_q <= rd_data_p1_q;
      end
    end
  end

  assign ram_if.rd_v_out = rd_v_p2_q;
  assign ram_if.rd_out   = rd_data_p2_q;
`else
  assign ram_if.rd_v_out = rd_v_p1_q;
  assign ram_if.rd_out   = rd_data_p1_q;
`endif

  assign ram_if.ready_out = ready;

endmodule
